// File: rtl/adder_n21_pipe.sv
// Pipelined N-operand adder/subtractor. Each stage adds one STAGE_WIDTH chunk of every operand.
// Operands are skewed in and result chunks deskewed out, so a whole result leaves in one cycle.
module adder_n21_pipe #(
    parameter  int N_OPS       = 4,
    parameter  int IN_WIDTH    = 1024,
    parameter  int STAGE_WIDTH = 128,
    localparam int NUM_STAGES  = IN_WIDTH / STAGE_WIDTH,
    localparam int CW          = $clog2(N_OPS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_OPS*IN_WIDTH-1:0] in_ops,
    input  logic [N_OPS-1:0]          in_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH-1:0]       out_sum,
    output logic [CW-1:0]             out_cout
);

    localparam int W = STAGE_WIDTH;
    localparam int S = NUM_STAGES;

    logic          en;
    logic          stage_vld [S];
    logic [CW-1:0] stage_cy  [S];

    // A single stall enable freezes every register in the pipe at once.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = stage_vld[S-1];
    assign out_cout  = stage_cy[S-1];

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [W-1:0]    opc [N_OPS];
        logic [CW-1:0]   cin;
        logic            vin;
        logic [W+CW-1:0] total;
        logic            vld_q;
        logic [CW-1:0]   cy_q;
        logic [W-1:0]    chunk_q;

        if (k == 0) begin : g_head
            // Inverting the subtracted operands and adding one per inversion gives two's complement.
            always_comb begin
                for (int i = 0; i < N_OPS; i++) begin
                    opc[i] = in_ops[i*IN_WIDTH +: W] ^ {W{in_sub[i]}};
                end
            end

            assign cin = CW'($countones(in_sub));
            assign vin = in_valid;
        end else begin : g_skew
            logic [N_OPS*W-1:0] skew_in;
            logic [N_OPS*W-1:0] skew_q [k];

            // The mode is applied on entry, so the skewed chunks already carry the inversion.
            always_comb begin
                for (int i = 0; i < N_OPS; i++) begin
                    skew_in[i*W +: W] = in_ops[i*IN_WIDTH + k*W +: W] ^ {W{in_sub[i]}};
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    skew_q[0] <= skew_in;
                    for (int d = 1; d < k; d++) begin
                        skew_q[d] <= skew_q[d-1];
                    end
                end
            end

            always_comb begin
                for (int i = 0; i < N_OPS; i++) begin
                    opc[i] = skew_q[k-1][i*W +: W];
                end
            end

            assign cin = stage_cy[k-1];
            assign vin = stage_vld[k-1];
        end

        // The sum is bounded by N_OPS * 2^W, so the carry always fits in CW bits.
        always_comb begin
            total = {{W{1'b0}}, cin};
            for (int i = 0; i < N_OPS; i++) begin
                total = total + {{CW{1'b0}}, opc[i]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q   <= 1'b0;
                cy_q    <= '0;
                chunk_q <= '0;
            end else if (en) begin
                vld_q   <= vin;
                cy_q    <= total[W +: CW];
                chunk_q <= total[W-1:0];
            end
        end

        assign stage_vld[k] = vld_q;
        assign stage_cy[k]  = cy_q;

        if (k < S - 1) begin : g_deskew
            logic [W-1:0] dsk_q [S-1-k];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < S - 1 - k; d++) begin
                        dsk_q[d] <= '0;
                    end
                end else if (en) begin
                    dsk_q[0] <= chunk_q;
                    for (int d = 1; d < S - 1 - k; d++) begin
                        dsk_q[d] <= dsk_q[d-1];
                    end
                end
            end

            assign out_sum[k*W +: W] = dsk_q[S-2-k];
        end else begin : g_tail
            assign out_sum[k*W +: W] = chunk_q;
        end
    end

endmodule
